edcc_pipe: RTL and testbench

Parametrised, pipelined SEC-DED (extended Hamming) error detection and correction stage for main-memory read data. It takes one data word, its stored check bits and the access address per beat through a valid/ready handshake. Two pipeline cycles later it returns corrected data with corrected and uncorrectable flags. It also keeps saturating error counters and a sticky capture of the first uncorrectable address. It sits between the main memory read port and the Wishbone read-data return path, and it generalises the combinational `edcc_mod` to any data width, adds back-pressure, bypass mode and error logging.

---
 rtl/edcc_pipe.sv | 166 ++++++++++++++++
 tb/tb_edcc_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/edcc_pipe.sv
// Two-stage pipelined SEC-DED (extended Hamming) check/correct stage for memory read data,
// with valid/ready flow control, bypass, saturating error counters and first-UE address capture.
module edcc_pipe #(
  parameter int unsigned WB_DWIDTH  = 32,
  parameter int unsigned ECC_WIDTH  = 7,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [WB_DWIDTH-1:0]  i_main_dat,
  input  logic [ECC_WIDTH-1:0]  i_ecc_dat,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_bypass,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WB_DWIDTH-1:0]  o_dat,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_corrected,
  output logic                  o_uncorrectable,
  input  logic                  i_clr_counts,
  output logic [CNT_WIDTH-1:0]  o_ce_count,
  output logic [CNT_WIDTH-1:0]  o_ue_count,
  output logic [ADDR_WIDTH-1:0] o_err_addr,
  output logic                  o_err_addr_vld
);

  localparam int unsigned H = ECC_WIDTH - 1;             // Hamming check bits
  localparam int unsigned N = WB_DWIDTH + ECC_WIDTH - 1; // highest codeword position

  // Codeword position of data bit idx: the (idx+1)-th non-power-of-two position.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned q = 3; q <= N; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (cnt == idx) pos = q;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic                  s1_valid;
  logic [WB_DWIDTH-1:0]  s1_dat;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic                  s1_bypass;
  logic [H-1:0]          s1_syn;
  logic                  s1_pe;

  logic [H-1:0]          calc_c;
  logic [H-1:0]          syn;
  logic                  pe;
  logic                  adv2;
  logic                  accept;
  logic                  xfer;

  logic [31:0]           syn_ext;
  logic [WB_DWIDTH-1:0]  flip;
  logic [WB_DWIDTH-1:0]  dec_dat;
  logic                  dec_corr;
  logic                  dec_unc;

  assign adv2    = !o_valid || i_ready;
  assign o_ready = !s1_valid || adv2;
  assign accept  = i_valid && o_ready;
  assign xfer    = o_valid && i_ready;

  always_comb begin
    calc_c = '0;
    for (int i = 0; i < WB_DWIDTH; i++) begin
      for (int j = 0; j < H; j++) begin
        if (((data_pos(i) >> j) & 1) != 0) calc_c[j] = calc_c[j] ^ i_main_dat[i];
      end
    end
  end

  assign syn = calc_c ^ i_ecc_dat[H-1:0];
  assign pe  = ^{i_main_dat, i_ecc_dat};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid  <= 1'b0;
      s1_dat    <= '0;
      s1_addr   <= '0;
      s1_bypass <= 1'b0;
      s1_syn    <= '0;
      s1_pe     <= 1'b0;
    end else if (o_ready) begin
      s1_valid <= i_valid;
      if (accept) begin
        s1_dat    <= i_main_dat;
        s1_addr   <= i_addr;
        s1_bypass <= i_bypass;
        s1_syn    <= syn;
        s1_pe     <= pe;
      end
    end
  end

  assign syn_ext = 32'(s1_syn);

  always_comb begin
    flip = '0;
    for (int i = 0; i < WB_DWIDTH; i++) begin
      flip[i] = (syn_ext == data_pos(i));
    end
  end

  // Syndromes pointing at a check-bit position flip nothing: flip stays all-zero.
  always_comb begin
    dec_dat  = s1_dat;
    dec_corr = 1'b0;
    dec_unc  = 1'b0;
    if (!s1_bypass) begin
      if (syn_ext == 0) begin
        dec_corr = s1_pe;
      end else if (s1_pe && (syn_ext <= N)) begin
        dec_dat  = s1_dat ^ flip;
        dec_corr = 1'b1;
      end else begin
        dec_unc = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid         <= 1'b0;
      o_dat           <= '0;
      o_addr          <= '0;
      o_corrected     <= 1'b0;
      o_uncorrectable <= 1'b0;
    end else if (adv2) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_dat           <= dec_dat;
        o_addr          <= s1_addr;
        o_corrected     <= dec_corr;
        o_uncorrectable <= dec_unc;
      end
    end
  end

  // Clear has priority; an event coinciding with it is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_counts) begin
      o_ce_count     <= '0;
      o_ue_count     <= '0;
      o_err_addr     <= '0;
      o_err_addr_vld <= 1'b0;
    end else if (xfer) begin
      if (o_corrected && (o_ce_count != '1)) o_ce_count <= o_ce_count + 1'b1;
      if (o_uncorrectable && (o_ue_count != '1)) o_ue_count <= o_ue_count + 1'b1;
      if (o_uncorrectable && !o_err_addr_vld) begin
        o_err_addr     <= o_addr;
        o_err_addr_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_edcc_pipe.sv
// Directed bench for edcc_pipe: decode rules, latency, back-pressure, logging, clear,
// saturation (4-bit counters) and mid-stream reset.
module tb_edcc_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_main_dat;
  logic [6:0]  i_ecc_dat;
  logic [31:0] i_addr;
  logic        i_bypass;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_dat;
  logic [31:0] o_addr;
  logic        o_corrected;
  logic        o_uncorrectable;
  logic        i_clr_counts;
  logic [3:0]  o_ce_count;
  logic [3:0]  o_ue_count;
  logic [31:0] o_err_addr;
  logic        o_err_addr_vld;

  int checks = 0;
  int passed = 0;

  edcc_pipe #(
    .WB_DWIDTH (32),
    .ECC_WIDTH (7),
    .ADDR_WIDTH(32),
    .CNT_WIDTH (4)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_main_dat     (i_main_dat),
    .i_ecc_dat      (i_ecc_dat),
    .i_addr         (i_addr),
    .i_bypass       (i_bypass),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_dat          (o_dat),
    .o_addr         (o_addr),
    .o_corrected    (o_corrected),
    .o_uncorrectable(o_uncorrectable),
    .i_clr_counts   (i_clr_counts),
    .o_ce_count     (o_ce_count),
    .o_ue_count     (o_ue_count),
    .o_err_addr     (o_err_addr),
    .o_err_addr_vld (o_err_addr_vld)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic counts(input string tag, input int ce, input int ue, input logic vld,
                        input logic [31:0] ea);
    check({tag, "_ce"}, 64'(o_ce_count), 64'(ce));
    check({tag, "_ue"}, 64'(o_ue_count), 64'(ue));
    check({tag, "_vld"}, 64'(o_err_addr_vld), 64'(vld));
    if (vld) check({tag, "_eaddr"}, 64'(o_err_addr), 64'(ea));
  endtask

  // Called at a negedge with the pipe empty; returns at a negedge after the output transfer.
  task automatic beat(input string tag, input logic [31:0] d, input logic [6:0] e,
                      input logic [31:0] a, input logic byp, input logic [31:0] xd,
                      input logic xc, input logic xu, input logic clr);
    i_valid = 1'b1; i_main_dat = d; i_ecc_dat = e; i_addr = a; i_bypass = byp; i_ready = 1'b1;
    #1 check({tag, "_rdy"}, 64'(o_ready), 64'(1));
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0;
    check({tag, "_lat"}, 64'(o_valid), 64'(0));
    @(posedge i_clk); @(negedge i_clk);
    check({tag, "_vld"}, 64'(o_valid), 64'(1));
    check({tag, "_dat"}, 64'(o_dat), 64'(xd));
    check({tag, "_addr"}, 64'(o_addr), 64'(a));
    check({tag, "_corr"}, 64'(o_corrected), 64'(xc));
    check({tag, "_unc"}, 64'(o_uncorrectable), 64'(xu));
    i_clr_counts = clr;
    @(posedge i_clk); @(negedge i_clk);
    i_clr_counts = 1'b0;
  endtask

  logic [31:0] s_dat [8];
  logic [6:0]  s_ecc [8];
  logic        s_byp [8];
  int          in_idx, out_idx, inflight;
  logic        acc, xf, stalled_prev;
  logic [31:0] held_dat, held_addr;

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_main_dat = '0; i_ecc_dat = '0; i_addr = '0;
    i_bypass = 1'b0; i_ready = 1'b1; i_clr_counts = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_ovalid", 64'(o_valid), 64'(0));
    check("rst_oready", 64'(o_ready), 64'(1));
    check("rst_odat", 64'(o_dat), 64'(0));
    check("rst_oaddr", 64'(o_addr), 64'(0));
    check("rst_flags", 64'({o_corrected, o_uncorrectable}), 64'(0));
    check("rst_eaddr", 64'(o_err_addr), 64'(0));
    counts("rst", 0, 0, 1'b0, '0);
    @(negedge i_clk);

    beat("clean", 32'h1, 7'h43, 32'h100, 1'b0, 32'h1, 1'b0, 1'b0, 1'b0);
    counts("clean", 0, 0, 1'b0, '0);
    beat("d0flip", 32'h0, 7'h43, 32'h104, 1'b0, 32'h1, 1'b1, 1'b0, 1'b0);
    counts("d0flip", 1, 0, 1'b0, '0);
    beat("c0flip", 32'h1, 7'h42, 32'h108, 1'b0, 32'h1, 1'b1, 1'b0, 1'b0);
    counts("c0flip", 2, 0, 1'b0, '0);
    beat("pflip", 32'h1, 7'h03, 32'h10c, 1'b0, 32'h1, 1'b1, 1'b0, 1'b0);
    counts("pflip", 3, 0, 1'b0, '0);
    // data bit 31 lives at position 38 = N: the highest correctable syndrome
    beat("d31flip", 32'h0, 7'h26, 32'h110, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0);
    counts("d31flip", 4, 0, 1'b0, '0);
    beat("dbl1", 32'h2, 7'h43, 32'h2000, 1'b0, 32'h2, 1'b0, 1'b1, 1'b0);
    counts("dbl1", 4, 1, 1'b1, 32'h2000);
    beat("dbl2", 32'h2, 7'h43, 32'h3000, 1'b0, 32'h2, 1'b0, 1'b1, 1'b0);
    counts("dbl2", 4, 2, 1'b1, 32'h2000);
    // syndrome 39 > N with odd parity
    beat("synbig", 32'h0, 7'h67, 32'h3004, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    counts("synbig", 4, 3, 1'b1, 32'h2000);
    beat("bypass", 32'h2, 7'h43, 32'h3008, 1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
    counts("bypass", 4, 3, 1'b1, 32'h2000);

    // Streaming with a 3-cycle downstream stall
    s_dat = '{32'h1, 32'hdeadbeef, 32'h0, 32'h12345678, 32'h1, 32'ha5a5a5a5, 32'h0, 32'hffffffff};
    s_ecc = '{7'h43, 7'h43, 7'h00, 7'h00, 7'h43, 7'h7f, 7'h00, 7'h43};
    s_byp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    in_idx = 0; out_idx = 0; inflight = 0; stalled_prev = 1'b0;
    held_dat = '0; held_addr = '0;
    for (int cyc = 0; cyc < 40 && out_idx < 8; cyc++) begin
      i_ready = !(cyc >= 5 && cyc < 8);
      if (in_idx < 8) begin
        i_valid = 1'b1; i_main_dat = s_dat[in_idx]; i_ecc_dat = s_ecc[in_idx];
        i_addr = 32'h600 + 32'(in_idx * 4); i_bypass = s_byp[in_idx];
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (stalled_prev) begin
        check("stall_vld", 64'(o_valid), 64'(1));
        check("stall_dat", 64'(o_dat), 64'(held_dat));
        check("stall_addr", 64'(o_addr), 64'(held_addr));
      end
      if (inflight == 2 && !i_ready) check("full_oready", 64'(o_ready), 64'(0));
      acc = i_valid && o_ready;
      xf  = o_valid && i_ready;
      if (xf) begin
        check("strm_dat", 64'(o_dat), 64'(s_dat[out_idx]));
        check("strm_addr", 64'(o_addr), 64'(32'h600 + 32'(out_idx * 4)));
        check("strm_flags", 64'({o_corrected, o_uncorrectable}), 64'(0));
        out_idx++;
      end
      stalled_prev = o_valid && !i_ready;
      held_dat = o_dat; held_addr = o_addr;
      @(posedge i_clk);
      if (acc) in_idx++;
      if (acc) inflight++;
      if (xf) inflight--;
      @(negedge i_clk);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    check("strm_count", 64'(out_idx), 64'(8));
    repeat (3) @(negedge i_clk);
    check("strm_nodup", 64'(o_valid), 64'(0));
    counts("strm", 4, 3, 1'b1, 32'h2000);

    // Clear coincides with an uncorrectable transfer: the event is dropped
    beat("clr", 32'h2, 7'h43, 32'h4000, 1'b0, 32'h2, 1'b0, 1'b1, 1'b1);
    counts("clr", 0, 0, 1'b0, '0);
    beat("recap", 32'h0, 7'h67, 32'h5000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    counts("recap", 0, 1, 1'b1, 32'h5000);

    // Saturation: 14 correctable beats reach all-ones minus 1, three more stay at all-ones
    i_main_dat = 32'h0; i_ecc_dat = 7'h43; i_bypass = 1'b0; i_addr = 32'h700;
    for (int n = 0; n < 14; n++) begin
      i_valid = 1'b1;
      @(posedge i_clk); @(negedge i_clk);
    end
    i_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    counts("sat14", 14, 1, 1'b1, 32'h5000);
    for (int n = 0; n < 3; n++) begin
      i_valid = 1'b1;
      @(posedge i_clk); @(negedge i_clk);
    end
    i_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    counts("sat17", 15, 1, 1'b1, 32'h5000);

    // Reset with a beat in flight
    i_valid = 1'b1; i_main_dat = 32'h1; i_ecc_dat = 7'h43; i_addr = 32'h800;
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0; i_rst = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("mrst_vld", 64'(o_valid), 64'(0));
    check("mrst_rdy", 64'(o_ready), 64'(1));
    counts("mrst", 0, 0, 1'b0, '0);
    repeat (3) @(negedge i_clk);
    check("mrst_drop", 64'(o_valid), 64'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
